// File: rtl/wakey_ctrl_pkg.sv
// Shared definitions for the wake-word sequencer.
// Contents: FSM state encodings (IDLE=0, CLEAR=1, LISTEN=2, HOLD=3),
// register word offsets (adr[3:2]), CTRL/STATUS bit positions and a
// saturating 16-bit increment used by the wake counter.
package wakey_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_LISTEN = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_HOLD    = 2'd2;
  localparam logic [1:0] REG_IRQ_CLR = 2'd3;

  localparam int unsigned CTRL_ARM        = 0;
  localparam int unsigned CTRL_IRQ_EN     = 1;
  localparam int unsigned CTRL_AUTO_REARM = 2;

  localparam int unsigned STATUS_IRQ_PEND = 3;
  localparam int unsigned STATUS_CNT_LSB  = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wakey_seq_ctrl_if.sv
// Wishbone classic slave bus bundle for wakey_seq_ctrl.
// Signals keep the management SoC port names:
//   wbs_stb_i/wbs_cyc_i/wbs_we_i  strobe, cycle, write enable
//   wbs_sel_i[3:0]                byte selects
//   wbs_adr_i[31:0]               byte address
//   wbs_dat_i[31:0]               write data
//   wbs_ack_o                     single-cycle acknowledge
//   wbs_dat_o[31:0]               read data (valid with ack, else 0)
// Modports: slave (the sequencer), master (SoC side / bench).
interface wakey_seq_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wakey_hold_timer.sv
// Loadable down-counter timing the wake_o hold window.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val (takes priority over counting)
//   load_val   value loaded, W bits
//   en         decrement by one per cycle (stops at zero)
//   done       high while the count equals 1, i.e. the last hold cycle
module wakey_hold_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/wakey_seq_ctrl.sv
// Wishbone-mapped sequencer for the wake-word pipeline.
// Firmware arms the pipeline; the block clears it for one cycle, enables it,
// and on a wake event drives wake_o for max(HOLD,1) cycles, sets IRQ_PEND and
// either re-arms (AUTO_REARM) or returns to IDLE clearing ARM.
// Ports:
//   wb_clk_i, wb_rst_i  clock, asynchronous active-high reset
//   wb                  Wishbone classic slave (wakey_seq_ctrl_if.slave)
//   wake_i              one-cycle wake pulse from the datapath
//   pipe_clr_o          datapath clear (CLEAR state)
//   pipe_en_o           datapath enable (LISTEN state)
//   wake_o              wake indication to pad (HOLD state)
//   irq_o               IRQ_PEND & IRQ_EN
// Registers (adr[3:2]): 0 CTRL, 1 STATUS, 2 HOLD, 3 IRQ_CLR.
// Build option: WAKEY_WAKE_CNT_EN builds the 16-bit saturating wake counter
// shown in STATUS[31:16]; without it those bits read 0.
module wakey_seq_ctrl
  import wakey_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned HOLD_W    = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wakey_seq_ctrl_if.slave wb,
  input  logic            wake_i,
  output logic            pipe_clr_o,
  output logic            pipe_en_o,
  output logic            wake_o,
  output logic            irq_o
);

  state_t state;
  state_t state_nx;

  logic arm_q;
  logic irq_en_q;
  logic auto_q;
  logic irq_pend_q;

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_load;
  logic [31:0]       byte_mask;
  logic [31:0]       hold_merged;

  logic [15:0] wake_cnt;

  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rdata;

  logic       hit;
  logic       acc;
  logic       wr;
  logic       rd;
  logic [1:0] reg_sel;

  logic ctrl_wr;
  logic hold_wr;
  logic irq_clr;
  logic take_wake;
  logic timer_done;
  logic hw_arm_clr;

  logic unused_ok;

  // Bus decode; the ack_q term keeps the held strobe of the just-acked
  // transfer from being accepted a second time.
  assign hit     = wb.wbs_stb_i & wb.wbs_cyc_i &
                   (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc     = hit & ~ack_q;
  assign wr      = acc & wb.wbs_we_i;
  assign rd      = acc & ~wb.wbs_we_i;
  assign reg_sel = wb.wbs_adr_i[3:2];

  assign ctrl_wr = wr && (reg_sel == REG_CTRL) && wb.wbs_sel_i[0];
  assign hold_wr = wr && (reg_sel == REG_HOLD);
  assign irq_clr = wr && (reg_sel == REG_IRQ_CLR) && wb.wbs_sel_i[0] &&
                   wb.wbs_dat_i[0];

  assign byte_mask   = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}},
                        {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
  assign hold_merged = (32'(hold_q) & ~byte_mask) | (wb.wbs_dat_i & byte_mask);

  assign hold_load  = (hold_q == '0) ? HOLD_W'(1) : hold_q;
  assign take_wake  = (state == ST_LISTEN) && arm_q && wake_i;
  assign hw_arm_clr = (state == ST_HOLD) && timer_done && !auto_q;

  assign unused_ok = &{1'b0, wb.wbs_adr_i[1:0], hold_merged};

  always_comb begin
    state_nx = state;
    if (!arm_q) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_nx = ST_CLEAR;
        ST_CLEAR:  state_nx = ST_LISTEN;
        ST_LISTEN: if (wake_i) state_nx = ST_HOLD;
        ST_HOLD:   if (timer_done) state_nx = auto_q ? ST_CLEAR : ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  wakey_hold_timer #(
    .W(HOLD_W)
  ) u_hold_timer (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (take_wake),
    .load_val (hold_load),
    .en       (state == ST_HOLD),
    .done     (timer_done)
  );

  // A firmware CTRL write outranks the hardware ARM clear in the same cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      arm_q    <= 1'b0;
      irq_en_q <= 1'b0;
      auto_q   <= 1'b0;
    end else if (ctrl_wr) begin
      arm_q    <= wb.wbs_dat_i[CTRL_ARM];
      irq_en_q <= wb.wbs_dat_i[CTRL_IRQ_EN];
      auto_q   <= wb.wbs_dat_i[CTRL_AUTO_REARM];
    end else if (hw_arm_clr) begin
      arm_q <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold_q <= HOLD_W'(1);
    end else if (hold_wr) begin
      hold_q <= hold_merged[HOLD_W-1:0];
    end
  end

  // Hardware set outranks a same-cycle IRQ_CLR write.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_pend_q <= 1'b0;
    end else if (take_wake) begin
      irq_pend_q <= 1'b1;
    end else if (irq_clr) begin
      irq_pend_q <= 1'b0;
    end
  end

`ifdef WAKEY_WAKE_CNT_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wake_cnt <= '0;
    end else if (take_wake) begin
      wake_cnt <= sat_inc16(wake_cnt);
    end
  end
`else
  assign wake_cnt = '0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_ARM]        = arm_q;
        rdata[CTRL_IRQ_EN]     = irq_en_q;
        rdata[CTRL_AUTO_REARM] = auto_q;
      end
      REG_STATUS: begin
        rdata[2:0]             = state;
        rdata[STATUS_IRQ_PEND] = irq_pend_q;
        rdata[STATUS_CNT_LSB +: 16] = wake_cnt;
      end
      REG_HOLD: rdata = 32'(hold_q);
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= rd ? rdata : '0;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

  assign pipe_clr_o = (state == ST_CLEAR);
  assign pipe_en_o  = (state == ST_LISTEN);
  assign wake_o     = (state == ST_HOLD);
  assign irq_o      = irq_pend_q & irq_en_q;

endmodule

// File: tb/tb_wakey_seq_ctrl.sv
module tb_wakey_seq_ctrl;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_HOLD   = BASE + 32'h8;
  localparam logic [31:0] A_IRQC   = BASE + 32'hC;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic wake = 1'b0;
  logic pipe_clr, pipe_en, wake_o, irq;

  always #5 clk = ~clk;

  wakey_seq_ctrl_if wb();

  wakey_seq_ctrl #(
    .BASE_ADDR(BASE),
    .HOLD_W(16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (wb),
    .wake_i     (wake),
    .pipe_clr_o (pipe_clr),
    .pipe_en_o  (pipe_en),
    .wake_o     (wake_o),
    .irq_o      (irq)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // reference state
  int unsigned exp_cnt  = 0;
  logic [15:0] exp_hold = 16'd1;
  logic        ack_wake;

  // pulse-width monitor
  int unsigned wake_q[$];
  int unsigned clr_q[$];
  int unsigned wrun = 0;
  int unsigned crun = 0;

  always @(negedge clk) begin
    if (rst) begin
      wrun = 0;
      crun = 0;
    end else begin
      if (wake_o) wrun++;
      else if (wrun != 0) begin wake_q.push_back(wrun); wrun = 0; end
      if (pipe_clr) crun++;
      else if (crun != 0) begin clr_q.push_back(crun); crun = 0; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_status(input logic [2:0] st, input logic pend);
    logic [15:0] c;
`ifdef WAKEY_WAKE_CNT_EN
    c = (exp_cnt > 65535) ? 16'hFFFF : 16'(exp_cnt);
`else
    c = 16'h0;
`endif
    return {c, 12'h000, pend, st};
  endfunction

  function automatic void bump_cnt();
    if (exp_cnt < 65535) exp_cnt++;
  endfunction

  // Master holds stb one cycle past ack to show the block does not re-ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, input bit pulse, output logic [31:0] rdat);
    int unsigned lat;
    lat = 0;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = wdat;
    wb.wbs_sel_i = sel;
    if (pulse) wake = 1'b1;
    do begin
      step();
      wake = 1'b0;
      lat++;
    end while (!wb.wbs_ack_o && lat < 8);
    chk("ack_latency", lat, 1);
    rdat     = wb.wbs_dat_o;
    ack_wake = wake_o;
    step();
    chk("ack_single", wb.wbs_ack_o, 0);
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, adr, d, 4'hF, 1'b0, r);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] r);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, 1'b0, r);
  endtask

  task automatic no_ack(input logic [31:0] adr);
    int unsigned acks;
    acks = 0;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = adr;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wb.wbs_ack_o) acks++;
    end
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    chk("no_ack_outside", acks, 0);
  endtask

  task automatic wait_listen();
    for (int i = 0; i < 12 && !pipe_en; i++) step();
    chk("listen_reached", pipe_en, 1);
  endtask

  task automatic wait_wake_low(input int unsigned limit);
    for (int unsigned i = 0; i < limit && wake_o; i++) step();
    chk("wake_end", wake_o, 0);
  endtask

  task automatic check_pulses(input int unsigned nw, input int unsigned ew, input int unsigned nclr);
    chk("wake_pulse_count", wake_q.size(), nw);
    foreach (wake_q[i]) chk("wake_width", wake_q[i], ew);
    chk("clr_pulse_count", clr_q.size(), nclr);
    foreach (clr_q[i]) chk("clr_width", clr_q[i], 1);
  endtask

  task automatic run_scn(input logic [15:0] hv, input bit ar, input bit ien, input int unsigned nw);
    logic [31:0] r;
    int unsigned ew;
    ew = (hv == 16'd0) ? 1 : int'(hv);
    wb_wr(A_HOLD, {16'h0, hv});
    exp_hold = hv;
    clr_q.delete();
    wake_q.delete();
    wb_wr(A_CTRL, {29'd0, ar, ien, 1'b1});
    for (int unsigned k = 0; k < nw; k++) begin
      wait_listen();
      repeat ($urandom_range(0, 4)) step();
      wake = 1'b1;
      step();
      wake = 1'b0;
      bump_cnt();
      chk("wake_rise", wake_o, 1);
      chk("irq_on_wake", irq, {31'd0, ien});
      chk("en_off_in_hold", pipe_en, 0);
      wait_wake_low(ew + 4);
    end
    if (ar) begin
      wait_listen();
      wb_rd(A_STATUS, r);
      chk("status_rearmed", r, exp_status(3'd2, 1'b1));
      wb_wr(A_CTRL, 32'h0);
    end else begin
      step();
      wb_rd(A_CTRL, r);
      chk("ctrl_arm_cleared", r, {30'd0, ien, 1'b0});
    end
    wb_rd(A_STATUS, r);
    chk("status_idle", r, exp_status(3'd0, 1'b1));
    check_pulses(nw, ew, ar ? nw + 1 : 1);
    wb_wr(A_IRQC, 32'h1);
    chk("irq_cleared", irq, 0);
    wb_rd(A_STATUS, r);
    chk("pend_cleared", r, exp_status(3'd0, 1'b0));
  endtask

  initial begin
    logic [31:0] r;
    bit ar, ien;
    logic [15:0] hv;

    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;

    repeat (3) step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_pipe_clr", pipe_clr, 0);
    chk("rst_pipe_en", pipe_en, 0);
    chk("rst_wake_o", wake_o, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ack", wb.wbs_ack_o, 0);
    chk("rst_dat", wb.wbs_dat_o, 0);
    wb_rd(A_STATUS, r);
    chk("rst_status", r, 32'h0);
    wb_rd(A_CTRL, r);
    chk("rst_ctrl", r, 32'h0);
    wb_rd(A_HOLD, r);
    chk("rst_hold", r, 32'h1);

    // wake_i ignored while idle
    wake = 1'b1;
    step();
    wake = 1'b0;
    chk("idle_wake_ignored", wake_o, 0);
    wb_rd(A_STATUS, r);
    chk("idle_status", r, exp_status(3'd0, 1'b0));

    // directed scenarios
    run_scn(16'd3, 1'b1, 1'b1, 2);   // CTRL=0x7, two wakes
    run_scn(16'd5, 1'b0, 1'b1, 1);   // CTRL=0x3, HOLD=5
    run_scn(16'd0, 1'b0, 1'b0, 1);   // HOLD=0 -> one cycle
    run_scn(16'd1, 1'b0, 1'b1, 1);

    // same-cycle hardware set and IRQ_CLR: set wins
    wb_wr(A_HOLD, 32'd3);
    wb_wr(A_CTRL, 32'h3);
    wait_listen();
    wb_xfer(1'b1, A_IRQC, 32'h1, 4'hF, 1'b1, r);
    bump_cnt();
    chk("irq_set_wins_out", irq, 1);
    wb_rd(A_STATUS, r);
    chk("irq_set_wins_pend", r[3], 1);
    wait_wake_low(8);
    step();
    wb_wr(A_IRQC, 32'h1);
    chk("irq_clr_alone", irq, 0);

    // ARM cleared during HOLD
    wb_wr(A_HOLD, 32'd10);
    wb_wr(A_CTRL, 32'h5);
    wait_listen();
    wake = 1'b1;
    step();
    wake = 1'b0;
    bump_cnt();
    step();
    step();
    wb_wr(A_CTRL, 32'h0);
    chk("abort_wake_at_ack", ack_wake, 1);
    chk("abort_wake_drop", wake_o, 0);
    chk("abort_en", pipe_en, 0);
    chk("abort_irq_masked", irq, 0);
    wb_rd(A_STATUS, r);
    chk("abort_status", r, exp_status(3'd0, 1'b1));
    repeat (3) step();
    chk("abort_stays_idle", wake_o | pipe_en | pipe_clr, 0);
    wb_wr(A_IRQC, 32'h1);
    exp_hold = 16'd10;

    // decode misses
    no_ack(BASE + 32'h10);
    no_ack(BASE ^ 32'h1000_0000);

    // byte enables
    wb_xfer(1'b1, A_HOLD, 32'h1234_ABCD, 4'b0010, 1'b0, r);
    exp_hold = (exp_hold & 16'h00FF) | 16'hAB00;
    wb_rd(A_HOLD, r);
    chk("hold_byte_sel", r, {16'h0, exp_hold});
    wb_xfer(1'b1, A_CTRL, 32'h0000_0007, 4'b1110, 1'b0, r);
    wb_rd(A_CTRL, r);
    chk("ctrl_byte0_masked", r, 32'h0);

    // randomized scenarios
    for (int it = 0; it < 8; it++) begin
      hv  = 16'($urandom_range(0, 9));
      ar  = 1'($urandom_range(0, 1));
      ien = 1'($urandom_range(0, 1));
      run_scn(hv, ar, ien, ar ? $urandom_range(1, 3) : 1);
    end

    // asynchronous reset in HOLD
    wb_wr(A_HOLD, 32'd8);
    wb_wr(A_CTRL, 32'h3);
    wait_listen();
    wake = 1'b1;
    step();
    wake = 1'b0;
    step();
    chk("pre_reset_wake", wake_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_wake", wake_o, 0);
    chk("async_rst_irq", irq, 0);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    exp_cnt  = 0;
    exp_hold = 16'd1;
    step();
    wb_rd(A_STATUS, r);
    chk("post_rst_status", r, exp_status(3'd0, 1'b0));
    wb_rd(A_CTRL, r);
    chk("post_rst_ctrl", r, 32'h0);
    wb_rd(A_HOLD, r);
    chk("post_rst_hold", r, {16'h0, exp_hold});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
